// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered 8-bit UART transmitter. Bytes written over a valid/ready port are
//   queued in a small FIFO and serialised LSB first onto tx. Each frame has an
//   optional parity bit and one or two stop bits. The bit period is baud_div+1
//   HCLK cycles.
//
// Ports
//   HCLK       system clock, all logic on posedge
//   HRESET     synchronous reset, active-high
//   en         0: finish the current frame but start no new one
//   baud_div   bit period minus one, in HCLK cycles
//   par_en     1: append a parity bit after the data bits
//   par_odd    1: odd parity, 0: even parity
//   stop2      1: two stop bits
//   wr_data    byte to queue
//   wr_valid   write request
//   wr_ready   FIFO can accept a byte (not full)
//   level      FIFO occupancy
//   busy       frame in progress or FIFO non-empty
//   tx         serial line, idle high
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV_W = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     en,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic                     par_en,
  input  logic                     par_odd,
  input  logic                     stop2,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     tx
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [DIV_W-1:0] TMR_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Frame engine
  state_t           state;
  state_t           state_n;
  logic [DIV_W-1:0] tmr;
  logic [DIV_W-1:0] div_l;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             par_en_l;
  logic             stop2_l;
  logic             par_bit;
  logic             tx_q;
  logic             tx_n;
  logic             bit_end;
  logic             last_data;
  logic             last_stop;
  logic             can_start;

  // Ready comes from the registered count only, so a full FIFO refuses a
  // write even in a cycle where the transmitter pops.
  assign wr_ready = (count != LVL_FULL);
  assign push     = wr_valid & wr_ready;
  assign head     = mem[rd_ptr];
  assign level    = count;
  assign busy     = (state != S_IDLE) || (count != '0);
  assign tx       = tx_q;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_ONE;
        2'b01:   count <= count - LVL_ONE;
        default: count <= count;
      endcase
    end
  end

  assign bit_end   = (tmr == div_l);
  assign last_data = (bit_cnt == 3'd7);
  assign last_stop = (bit_cnt == {2'b00, stop2_l});
  assign can_start = en && (count != '0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // tx_n is the line level for the current state; it is registered into
  // tx_q, so the line trails the state by one cycle with unchanged bit widths.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          state_n = S_DATA;
        end
      end
      S_DATA: begin
        tx_n = shift[0];
        if (bit_end && last_data) begin
          state_n = par_en_l ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_n = par_bit;
        if (bit_end) begin
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (bit_end && last_stop) begin
          // Next byte waiting: chain straight into its start bit.
          if (can_start) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      tmr      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      div_l    <= '0;
      par_en_l <= 1'b0;
      stop2_l  <= 1'b0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_q <= tx_n;

      if ((state == S_IDLE) || bit_end) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + TMR_ONE;
      end

      if (state_n != state) begin
        bit_cnt <= '0;
      end else if (bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Frame settings are captured at pop time so that runtime changes only
      // affect the next frame.
      if (pop) begin
        shift    <= head;
        div_l    <= baud_div;
        par_en_l <= par_en;
        stop2_l  <= stop2;
        par_bit  <= (^head) ^ par_odd;
      end else if ((state == S_DATA) && bit_end) begin
        shift <= {1'b0, shift[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DIV_W = 16;

  logic             HCLK = 1'b0;
  logic             HRESET = 1'b1;
  logic             en = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic             par_en = 1'b0;
  logic             par_odd = 1'b0;
  logic             stop2 = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [2:0]       level;
  logic             busy;
  logic             tx;

  uart_tx_fifo #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .en       (en),
    .baud_div (baud_div),
    .par_en   (par_en),
    .par_odd  (par_odd),
    .stop2    (stop2),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .level    (level),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 HCLK = ~HCLK;

  longint cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    bit         par_en;
    bit         exp_par;
    bit         stop2;
    int         period;
    bit         b2b;
    longint     start_at;
  } exp_t;

  exp_t sb[$];
  bit   mon_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input bit pe, input bit pb,
                              input bit s2, input int per, input bit b2b,
                              input longint start_at);
    exp_t e;
    e.data = d; e.par_en = pe; e.exp_par = pb; e.stop2 = s2;
    e.period = per; e.b2b = b2b; e.start_at = start_at;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [7:0] d, output bit acc, output longint acyc);
    @(negedge HCLK);
    wr_data  = d;
    wr_valid = 1'b1;
    acc      = wr_ready;
    @(posedge HCLK);
    #1;
    acyc     = cyc;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < bound) begin
      @(posedge HCLK);
      n++;
    end
    chk("frames_drained", sb.size() + int'(mon_busy), 0);
    repeat (3) @(posedge HCLK);
  endtask

  // Serial monitor: on each start bit, pop the expected frame and compare the
  // line cycle by cycle against the waveform the frame should produce.
  initial begin : monitor
    exp_t       e;
    logic [11:0] bits;
    logic [7:0] rx;
    int         nb, len, idx, bad_at;
    longint     start;
    longint     last_end = -1;
    bit         aborted;
    forever begin
      @(negedge HCLK);
      if (!HRESET && tx === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame actual=start_bit required=idle_line cyc=%0d", cyc);
          while (tx === 1'b0) @(negedge HCLK);
          last_end = -1;
        end else begin
          e = sb.pop_front();
          mon_busy = 1'b1;
          start = cyc;
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < 8; i++) bits[1+i] = e.data[i];
          if (e.par_en) bits[9] = e.exp_par;
          nb = 10 + int'(e.par_en) + int'(e.stop2);
          len = nb * e.period;
          if (e.start_at >= 0) chk("start_latency", start, e.start_at);
          if (e.b2b) chk("b2b_gap", start, last_end);
          bad_at = 0;
          aborted = 1'b0;
          rx = '0;
          for (int off = 0; off < len; off++) begin
            if (HRESET) begin
              aborted = 1'b1;
              break;
            end
            idx = off / e.period;
            if (tx !== bits[idx] && bad_at == 0) bad_at = off + 1;
            if (idx >= 1 && idx <= 8 && (off % e.period) == e.period / 2) rx[idx-1] = tx;
            if (off < len - 1) @(negedge HCLK);
          end
          if (!aborted) begin
            chk($sformatf("frame_%02h_wave_bad_offset_plus1", e.data), bad_at, 0);
            chk($sformatf("frame_%02h_byte", e.data), rx, e.data);
            last_end = start + len;
          end else begin
            last_end = -1;
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit     acc;
    longint a;

    // Power-on reset
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_level", level, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_ready", wr_ready, 1);

    // 0x41 at baud_div=15: start bit two cycles after accept, 160-cycle frame
    baud_div = 16'd15;
    en = 1'b1;
    wr(8'h41, acc, a);
    chk("accept_41", acc, 1);
    expect_frame(8'h41, 0, 0, 0, 16, 0, a + 2);
    chk("busy_after_accept", busy, 1);
    wait_done(600);

    // Fill with en=0, fifth write dropped, then four back-to-back frames
    en = 1'b0;
    wr(8'h11, acc, a); expect_frame(8'h11, 0, 0, 0, 16, 0, -1);
    wr(8'h22, acc, a); expect_frame(8'h22, 0, 0, 0, 16, 1, -1);
    wr(8'h33, acc, a); expect_frame(8'h33, 0, 0, 0, 16, 1, -1);
    wr(8'h44, acc, a); expect_frame(8'h44, 0, 0, 0, 16, 1, -1);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_level", level, 4);
    wr(8'h55, acc, a);
    chk("accept_55_refused", acc, 0);
    chk("level_after_drop", level, 4);
    @(negedge HCLK);
    en = 1'b1;
    wait_done(1200);

    // Parity: 0x07 has three ones -> even parity bit 1, odd parity bit 0
    par_en = 1'b1;
    par_odd = 1'b0;
    wr(8'h07, acc, a);
    expect_frame(8'h07, 1, 1, 0, 16, 0, a + 2);
    wait_done(600);
    par_odd = 1'b1;
    wr(8'h07, acc, a);
    expect_frame(8'h07, 1, 0, 0, 16, 0, a + 2);
    wait_done(600);

    // Two stop bits with odd parity, two chained 192-cycle frames
    en = 1'b0;
    stop2 = 1'b1;
    wr(8'h5A, acc, a); expect_frame(8'h5A, 1, 1, 1, 16, 0, -1);
    wr(8'hC3, acc, a); expect_frame(8'hC3, 1, 1, 1, 16, 1, -1);
    @(negedge HCLK);
    en = 1'b1;
    wait_done(800);

    // Full FIFO: pop and push in one cycle -> push refused; later a push
    // coinciding with a pop keeps level unchanged. baud_div=0 -> 10-cycle frames.
    en = 1'b0;
    par_en = 1'b0;
    par_odd = 1'b0;
    stop2 = 1'b0;
    baud_div = '0;
    wr(8'h81, acc, a); expect_frame(8'h81, 0, 0, 0, 1, 0, -1);
    wr(8'h42, acc, a); expect_frame(8'h42, 0, 0, 0, 1, 1, -1);
    wr(8'h24, acc, a); expect_frame(8'h24, 0, 0, 0, 1, 1, -1);
    wr(8'h18, acc, a); expect_frame(8'h18, 0, 0, 0, 1, 1, -1);
    chk("fill2_level", level, 4);
    @(negedge HCLK);
    en = 1'b1;
    wr_data = 8'h99;
    wr_valid = 1'b1;
    acc = wr_ready;
    @(posedge HCLK);
    #1;
    wr_valid = 1'b0;
    chk("full_push_refused", acc, 0);
    chk("level_after_full_pop", level, 3);
    repeat (9) @(posedge HCLK);
    @(negedge HCLK);
    wr_data = 8'h66;
    wr_valid = 1'b1;
    acc = wr_ready;
    @(posedge HCLK);
    #1;
    wr_valid = 1'b0;
    chk("push_with_pop_accepted", acc, 1);
    chk("level_push_pop_same_cycle", level, 3);
    expect_frame(8'h66, 0, 0, 0, 1, 1, -1);
    wait_done(300);

    // baud_div change mid-frame only affects the next frame
    baud_div = 16'd15;
    wr(8'hA5, acc, a);
    expect_frame(8'hA5, 0, 0, 0, 16, 0, a + 2);
    repeat (40) @(posedge HCLK);
    baud_div = 16'd3;
    wr(8'h3C, acc, a);
    expect_frame(8'h3C, 0, 0, 0, 4, 1, -1);
    wait_done(800);

    // Reset mid-frame with a second byte queued: line idles, byte discarded
    baud_div = 16'd15;
    wr(8'h41, acc, a); expect_frame(8'h41, 0, 0, 0, 16, 0, a + 2);
    wr(8'h42, acc, a); expect_frame(8'h42, 0, 0, 0, 16, 1, -1);
    repeat (60) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    sb.delete();
    chk("tx_high_after_reset_edge", tx, 1);
    chk("level_cleared_in_reset", level, 0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_level", level, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_wr_ready", wr_ready, 1);
    repeat (250) @(posedge HCLK);
    #1;
    chk("no_resume_tx", tx, 1);
    chk("no_resume_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
